// File: rtl/wb_result_selector.sv
// Writeback result selector: picks ALU/load/PC+4/IMM data and drives the register-file write port plus forwarding tap.
// Latency 1 cycle for non-loads, 1 cycle after memRespValid for loads; inReady drops while a load response is outstanding.
// Optional macro WB_MISALIGN_TRAP_EN: misaligned LH/LHU/LW trap at acceptance instead of issuing the load.
module wb_result_selector #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [1:0]           wbSel,
    input  logic                 regWrite,
    input  logic [REGADDR_W-1:0] rd,
    input  logic [XLEN-1:0]      aluResult,
    input  logic [XLEN-1:0]      PC,
    input  logic [XLEN-1:0]      imm,
    input  logic [2:0]           loadType,
    input  logic                 memRespValid,
    input  logic [XLEN-1:0]      memReadData,
    output logic                 regWriteEn,
    output logic [REGADDR_W-1:0] regWriteAddr,
    output logic [XLEN-1:0]      regWriteData,
    output logic                 fwdValid,
    output logic [REGADDR_W-1:0] fwdAddr,
    output logic [XLEN-1:0]      fwdData,
    output logic                 trap
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC4 = 2'd2;

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [2:0] LT_LHU = 3'd5;

    state_t                 state;
    logic [REGADDR_W-1:0]   held_rd;
    logic                   held_reg_write;
    logic [2:0]             held_load_type;
    logic [1:0]             held_addr;

    logic [XLEN-1:0]        direct_data;
    logic [XLEN-1:0]        load_data;
    logic [7:0]             load_byte;
    logic [15:0]            load_half;
    logic                   misaligned;

    always_comb begin
        direct_data = imm;
        case (wbSel)
            SEL_ALU: direct_data = aluResult;
            SEL_PC4: direct_data = PC + 32'd4;
            default: direct_data = imm;
        endcase
    end

    // Lane selection uses the address captured at acceptance; the live bus has moved on.
    always_comb begin
        load_byte = 8'h00;
        case (held_addr)
            2'd0: load_byte = memReadData[7:0];
            2'd1: load_byte = memReadData[15:8];
            2'd2: load_byte = memReadData[23:16];
            default: load_byte = memReadData[31:24];
        endcase
        load_half = held_addr[1] ? memReadData[31:16] : memReadData[15:0];
        load_data = memReadData;
        case (held_load_type)
            LT_LB:  load_data = {{24{load_byte[7]}}, load_byte};
            LT_LH:  load_data = {{16{load_half[15]}}, load_half};
            LT_LBU: load_data = {24'h0, load_byte};
            LT_LHU: load_data = {16'h0, load_half};
            default: load_data = memReadData;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (loadType)
            LT_LB, LT_LBU: misaligned = 1'b0;
            LT_LH, LT_LHU: misaligned = aluResult[0];
            default:       misaligned = (aluResult[1:0] != 2'd0);
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            regWriteEn     <= 1'b0;
            regWriteAddr   <= '0;
            regWriteData   <= '0;
            trap           <= 1'b0;
            held_rd        <= '0;
            held_reg_write <= 1'b0;
            held_load_type <= 3'd0;
            held_addr      <= 2'd0;
        end else begin
            regWriteEn <= 1'b0;
            trap       <= 1'b0;
            case (state)
                IDLE: begin
                    if (inValid) begin
                        if (wbSel == SEL_MEM) begin
`ifdef WB_MISALIGN_TRAP_EN
                            if (misaligned) begin
                                trap <= 1'b1;
                            end else begin
                                held_rd        <= rd;
                                held_reg_write <= regWrite;
                                held_load_type <= loadType;
                                held_addr      <= aluResult[1:0];
                                state          <= WAIT_MEM;
                            end
`else
                            held_rd        <= rd;
                            held_reg_write <= regWrite;
                            held_load_type <= loadType;
                            held_addr      <= aluResult[1:0];
                            state          <= WAIT_MEM;
`endif
                        end else begin
                            regWriteAddr <= rd;
                            regWriteData <= direct_data;
                            regWriteEn   <= regWrite && (rd != '0);
                        end
                    end
                end
                WAIT_MEM: begin
                    if (memRespValid) begin
                        regWriteAddr <= held_rd;
                        regWriteData <= load_data;
                        regWriteEn   <= held_reg_write && (held_rd != '0);
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef WB_MISALIGN_TRAP_EN
    // Without the trap feature the misalignment check has no consumer.
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

    assign inReady  = (state == IDLE);
    assign fwdValid = regWriteEn;
    assign fwdAddr  = regWriteAddr;
    assign fwdData  = regWriteData;

endmodule
